cbus_mem_arbiter: RTL and testbench

//  Shares one single-port wide SRAM between NUM_REQ cbus width-converter masters.

---
 rtl/cbus_mem_arbiter_pkg.sv | 13 +
 rtl/rr_priority_sel.sv | 35 +++
 rtl/cbus_mem_arbiter.sv | 94 +++++++++
 tb/tb_cbus_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_mem_arbiter_pkg.sv
// Shared command encodings and helpers for the cbus SRAM arbiter.
// Command polarity matches the cbus width converters: 1 = read, 0 = write.
package cbus_mem_arbiter_pkg;

   localparam logic CMD_RD      = 1'b1;
   localparam logic CMD_WR      = 1'b0;
   localparam int   NUM_REQ_MAX = 8;

   function automatic int next_ptr(input int idx, input int num_req);
      return (idx == num_req - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping from NUM_REQ-1 back to 0. Returns a one-hot grant and its index.
module rr_priority_sel #(
   parameter int NUM_REQ = 2,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IW-1:0]      rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      grant_idx
);

   logic          found;
   int            j;
   logic [IW-1:0] jj;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      jj        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = IW'(j);
         if (!found && eligible[jj]) begin
            found     = 1'b1;
            grant[jj] = 1'b1;
            grant_idx = jj;
         end
      end
   end

endmodule

// File: rtl/cbus_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ cbus masters.
// Writes are accepted in the grant cycle; read data follows one cycle after rresp.
module cbus_mem_arbiter
   import cbus_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int AW      = 10,
   parameter int DW      = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req_req,
   input  logic [NUM_REQ-1:0]    req_cmd,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wrdata,
   output logic [NUM_REQ-1:0]    req_waccept,
   output logic [NUM_REQ-1:0]    req_rresp,
   output logic [DW-1:0]         rd_data,
   input  logic                  mem_hold,
   output logic                  mem_ce,
   output logic                  mem_we,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_wdata,
   input  logic [DW-1:0]         mem_rdata
);

   localparam int IW = $clog2(NUM_REQ);

   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      grant_idx;
   logic [NUM_REQ-1:0] rd_mask;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [AW-1:0]      addr_shadow;
   logic [AW-1:0]      sel_addr;
   logic [DW-1:0]      wdata_shadow;
   logic [DW-1:0]      sel_wdata;
   logic               sel_rd;
   logic               granted;

   // Reset gates eligibility so grants drop the instant reset_n falls.
   assign eligible = req_req & ~rd_mask & {NUM_REQ{reset_n & ~mem_hold}};

   rr_priority_sel #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_sel (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_rd    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wrdata[i*DW +: DW];
            sel_rd    = (req_cmd[i] == CMD_RD);
         end
      end
   end

   assign granted     = |grant;
   assign req_waccept = sel_rd ? '0 : grant;
   assign req_rresp   = sel_rd ? grant : '0;
   assign mem_ce      = granted;
   assign mem_we      = granted & ~sel_rd;
   // Idle cycles replay the last granted fields so the SRAM pins stay quiet.
   assign mem_addr    = granted ? sel_addr  : addr_shadow;
   assign mem_wdata   = granted ? sel_wdata : wdata_shadow;
   assign rd_data     = mem_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr       <= '0;
         rd_mask      <= '0;
         addr_shadow  <= '0;
         wdata_shadow <= '0;
      end else begin
         // A read winner sits out exactly its rresp-to-data cycle.
         rd_mask <= req_rresp;
         if (granted) begin
            rr_ptr       <= IW'(next_ptr(int'(grant_idx), NUM_REQ));
            addr_shadow  <= sel_addr;
            wdata_shadow <= sel_wdata;
         end
      end
   end

endmodule

// File: tb/tb_cbus_mem_arbiter.sv
// Bench for cbus_mem_arbiter: directed sequences, a vector table and random traffic
// checked every cycle against a behavioural arbitration and memory model.
module tb_cbus_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 64;
   localparam logic [AW-1:0] A0 = 10'h0A0;
   localparam logic [AW-1:0] A1 = 10'h1B1;
   localparam logic [DW-1:0] W0 = 64'h1111_2222_3333_4444;
   localparam logic [DW-1:0] W1 = 64'h5555_6666_7777_8888;
   localparam logic [DW-1:0] T1_DATA = 64'hA5A5_0000_1234_5678;
   localparam logic [DW-1:0] RD3_CONST = 64'hDEAD_BEEF_0BAD_F00D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_n = 1'b0;
   logic [1:0]      req_req = '0;
   logic [1:0]      req_cmd = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wrdata = '0;
   logic            mem_hold = 1'b0;
   logic [1:0]      req_waccept;
   logic [1:0]      req_rresp;
   logic [DW-1:0]   rd_data;
   logic            mem_ce;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   logic [2:0]      req_req3 = '0;
   logic [2:0]      req_cmd3 = '0;
   logic [3*AW-1:0] req_addr3 = '0;
   logic [3*DW-1:0] req_wrdata3 = '0;
   logic            mem_hold3 = 1'b0;
   logic [2:0]      req_waccept3;
   logic [2:0]      req_rresp3;
   logic [DW-1:0]   rd_data3;
   logic            mem_ce3;
   logic            mem_we3;
   logic [AW-1:0]   mem_addr3;
   logic [DW-1:0]   mem_wdata3;
   logic [DW-1:0]   mem_rdata3 = RD3_CONST;

   int n_cmp  = 0;
   int n_fail = 0;

   cbus_mem_arbiter #(.NUM_REQ(2), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset_n(reset_n), .req_req(req_req), .req_cmd(req_cmd),
      .req_addr(req_addr), .req_wrdata(req_wrdata), .req_waccept(req_waccept),
      .req_rresp(req_rresp), .rd_data(rd_data), .mem_hold(mem_hold),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   cbus_mem_arbiter #(.NUM_REQ(3), .AW(AW), .DW(DW)) dut3 (
      .clk(clk), .reset_n(reset_n), .req_req(req_req3), .req_cmd(req_cmd3),
      .req_addr(req_addr3), .req_wrdata(req_wrdata3), .req_waccept(req_waccept3),
      .req_rresp(req_rresp3), .rd_data(rd_data3), .mem_hold(mem_hold3),
      .mem_ce(mem_ce3), .mem_we(mem_we3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
   );

   // SRAM macro stand-in: write on the edge, read data registered for the next cycle.
   logic [DW-1:0] sram [0:1023];
   always @(posedge clk) begin
      if (mem_ce && mem_we)  sram[mem_addr] <= mem_wdata;
      if (mem_ce && !mem_we) mem_rdata <= sram[mem_addr];
   end

   // Reference model state.
   int            m_ptr = 0;
   bit [1:0]      m_mask = '0;
   logic [AW-1:0] m_sh_addr = '0;
   logic [DW-1:0] m_sh_wd = '0;
   bit            m_pend = 1'b0;
   logic [DW-1:0] m_pend_data = '0;
   logic [DW-1:0] exp_mem [0:1023];
   int            d_cand = -1;
   bit            d_rd = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wd = '0;

   typedef struct {
      logic [1:0]    req;
      logic [1:0]    cmd;
      logic          hold;
      logic [1:0]    wacc;
      logic [1:0]    rresp;
      logic          ce;
      logic          we;
      logic [AW-1:0] addr;
      logic          rd_chk;
   } vec_t;
   vec_t vt [13];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_mask = '0; m_sh_addr = '0; m_sh_wd = '0; m_pend = 1'b0;
   endtask

   // Expected outputs for the current inputs, from the arbitration rules.
   task automatic model_check();
      int            cand;
      int            j;
      logic [1:0]    ew;
      logic [1:0]    er;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      cand = -1;
      if (reset_n && !mem_hold)
         for (int k = 0; k < 2; k++) begin
            j = (m_ptr + k) % 2;
            if (cand < 0 && req_req[j] && !m_mask[j]) cand = j;
         end
      ew = '0; er = '0; ea = m_sh_addr; ed = m_sh_wd;
      if (cand >= 0) begin
         ea = req_addr[cand*AW +: AW];
         ed = req_wrdata[cand*DW +: DW];
         if (req_cmd[cand]) er[cand] = 1'b1;
         else               ew[cand] = 1'b1;
      end
      chk("model_waccept", 128'(req_waccept), 128'(ew));
      chk("model_rresp",   128'(req_rresp),   128'(er));
      chk("model_ce",      128'(mem_ce),      128'(cand >= 0));
      chk("model_we",      128'(mem_we),      128'(ew != 2'b00));
      chk("model_addr",    128'(mem_addr),    128'(ea));
      chk("model_wdata",   128'(mem_wdata),   128'(ed));
      if (reset_n && m_pend) chk("model_rd_data", 128'(rd_data), 128'(m_pend_data));
      d_cand = cand;
      d_rd   = (er != 2'b00);
      d_addr = ea;
      d_wd   = ed;
   endtask

   task automatic model_commit();
      if (!reset_n) model_reset();
      else begin
         m_mask = '0;
         m_pend = 1'b0;
         if (d_cand >= 0) begin
            m_ptr     = (d_cand + 1) % 2;
            m_sh_addr = d_addr;
            m_sh_wd   = d_wd;
            if (d_rd) begin
               m_mask[d_cand] = 1'b1;
               m_pend         = 1'b1;
               m_pend_data    = exp_mem[d_addr];
            end else exp_mem[d_addr] = d_wd;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic drive(input logic [1:0] rq, input logic [1:0] cm, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] w0,
                        input logic [DW-1:0] w1, input logic hd);
      req_req = rq; req_cmd = cm; req_addr = {a1, a0}; req_wrdata = {w1, w0}; mem_hold = hd;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      cycle();
      cycle();
      reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         sram[i]    = '0;
         exp_mem[i] = '0;
      end
      vt[0]  = '{2'b11, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, A0, 1'b0};
      vt[1]  = '{2'b11, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, A1, 1'b0};
      vt[2]  = '{2'b11, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, A0, 1'b0};
      vt[3]  = '{2'b11, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, A1, 1'b0};
      vt[4]  = '{2'b11, 2'b01, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, A0, 1'b0};
      vt[5]  = '{2'b11, 2'b01, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, A1, 1'b1};
      vt[6]  = '{2'b10, 2'b01, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, A1, 1'b0};
      for (int i = 7; i < 12; i++)
         vt[i] = '{2'b11, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, A1, 1'b0};
      vt[12] = '{2'b11, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, A0, 1'b0};

      @(posedge clk);
      #1;
      // Requests present during reset must not produce grants.
      drive(2'b11, 2'b00, A0, A1, W0, W1, 1'b0);
      #1;
      chk("rst_waccept", 128'(req_waccept), 128'(0));
      chk("rst_ce",      128'(mem_ce),      128'(0));
      chk("rst_addr",    128'(mem_addr),    128'(0));
      do_reset();

      // Write then read back 0x012 from master 0.
      drive(2'b01, 2'b00, 10'h012, '0, T1_DATA, '0, 1'b0);
      #1;
      chk("t1_waccept", 128'(req_waccept), 128'(2'b01));
      chk("t1_we",      128'(mem_we),      128'(1));
      chk("t1_addr",    128'(mem_addr),    128'(10'h012));
      chk("t1_wdata",   128'(mem_wdata),   128'(T1_DATA));
      cycle();
      drive(2'b01, 2'b01, 10'h012, '0, '0, '0, 1'b0);
      #1;
      chk("t1_rresp", 128'(req_rresp), 128'(2'b01));
      chk("t1_rd_we", 128'(mem_we),    128'(0));
      cycle();
      drive(2'b00, 2'b00, 10'h012, '0, '0, '0, 1'b0);
      #1;
      chk("t1_rd_data", 128'(rd_data), 128'(T1_DATA));
      cycle();

      // Reset the cycle after a read grant; pointer must restart at master 0.
      drive(2'b01, 2'b01, 10'h012, '0, '0, '0, 1'b0);
      #1;
      chk("t5_rresp", 128'(req_rresp), 128'(2'b01));
      cycle();
      reset_n = 1'b0;
      model_reset();
      drive(2'b11, 2'b00, A0, A1, W0, W1, 1'b0);
      #1;
      chk("t5_waccept", 128'(req_waccept), 128'(0));
      chk("t5_rresp",   128'(req_rresp),   128'(0));
      chk("t5_ce_we",   128'({mem_ce, mem_we}), 128'(0));
      chk("t5_addr",    128'(mem_addr),    128'(0));
      chk("t5_wdata",   128'(mem_wdata),   128'(0));
      cycle();
      reset_n = 1'b1;
      #1;
      chk("t5_first_grant", 128'(req_waccept), 128'(2'b01));
      cycle();

      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].req, vt[i].cmd, A0, A1, W0, W1, vt[i].hold);
         #1;
         chk($sformatf("vec%0d_waccept", i), 128'(req_waccept), 128'(vt[i].wacc));
         chk($sformatf("vec%0d_rresp", i),   128'(req_rresp),   128'(vt[i].rresp));
         chk($sformatf("vec%0d_ce_we", i),   128'({mem_ce, mem_we}), 128'({vt[i].ce, vt[i].we}));
         chk($sformatf("vec%0d_addr", i),    128'(mem_addr),    128'(vt[i].addr));
         if (vt[i].rd_chk) chk($sformatf("vec%0d_rd_data", i), 128'(rd_data), 128'(W0));
         cycle();
      end

      // Random traffic against the model, with one reset in the middle.
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         drive(2'($urandom), 2'($urandom), 10'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
               {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
         cycle();
      end

      // Three-master instance: lone master 2 wins from pointer 0, then pointer wraps.
      drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      do_reset();
      req_req3    = 3'b100;
      req_cmd3    = 3'b000;
      req_addr3   = {10'h2AB, 10'h0CD, 10'h055};
      req_wrdata3 = {64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
      #1;
      chk("t6_waccept", 128'(req_waccept3), 128'(3'b100));
      chk("t6_rresp",   128'(req_rresp3),   128'(3'b000));
      chk("t6_ce_we",   128'({mem_ce3, mem_we3}), 128'(2'b11));
      chk("t6_addr",    128'(mem_addr3),    128'(10'h2AB));
      chk("t6_wdata",   128'(mem_wdata3),   128'(64'hCAFE_0000_0000_0002));
      cycle();
      req_req3 = 3'b101;
      #1;
      chk("t6_wrap_grant", 128'(req_waccept3), 128'(3'b001));
      chk("t6_wrap_addr",  128'(mem_addr3),    128'(10'h055));
      cycle();
      mem_hold3 = 1'b1;
      #1;
      chk("t6_hold_ce",   128'({mem_ce3, mem_we3}), 128'(0));
      chk("t6_hold_addr", 128'(mem_addr3),  128'(10'h055));
      chk("t6_rd_data",   128'(rd_data3),   128'(RD3_CONST));
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
